reader_core: RTL

- Parametrised successor to the team's two-phase fetch/execute test core.
- Program RAM is filled through a valid/ready load port instead of a hard-coded init sequence.
- Executes 4-byte instructions over a generic register file with arithmetic, branch and halt.
- Exposes r0/r1/debug observation ports for board-level bring-up.

---
 rtl/reader_pkg.sv | 23 ++
 rtl/reader_alu.sv | 19 +
 rtl/reader_core.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reader_pkg.sv
// reader_pkg: opcode map, FSM state encoding and instruction geometry shared
// by the reader_core slice.
package reader_pkg;

  localparam int INSTR_BYTES = 4;

  localparam logic [7:0] OP_NOP   = 8'd0;
  localparam logic [7:0] OP_MOVI  = 8'd1;
  localparam logic [7:0] OP_LOAD  = 8'd2;
  localparam logic [7:0] OP_STORE = 8'd3;
  localparam logic [7:0] OP_ADD   = 8'd4;
  localparam logic [7:0] OP_SUB   = 8'd5;
  localparam logic [7:0] OP_JMP   = 8'd6;
  localparam logic [7:0] OP_JZ    = 8'd7;
  localparam logic [7:0] OP_HALT  = 8'd8;

  // Core states: LOAD -> FETCH -> EXEC -> FETCH ..., EXEC -> HALT
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

endpackage

// File: rtl/reader_alu.sv
// reader_alu: combinational add / subtract / zero-test on register operands.
// Both results wrap modulo 2^DATA_WIDTH.
module reader_alu
  import reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  a_zero
);

  assign sum    = a + b;
  assign diff   = a - b;
  assign a_zero = (a == '0);

endmodule

// File: rtl/reader_core.sv
// reader_core: byte-loaded program RAM feeding a two-phase fetch/execute core
// with a generic register file. Optional macro READER_TRACE_EN adds the
// trace_valid / trace_pc retirement outputs.
module reader_core
  import reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int RAMSIZE    = 64,
  parameter int DEBUG_ADDR = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [7:0]            load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [7:0]            ipointer,
  output logic [7:0]            opCode,
  output logic [DATA_WIDTH-1:0] r0,
  output logic [DATA_WIDTH-1:0] r1,
  output logic [DATA_WIDTH-1:0] debug,
  output logic                  halted,
  output logic                  illegal
`ifdef READER_TRACE_EN
  ,
  output logic                  trace_valid,
  output logic [7:0]            trace_pc
`endif
);

  localparam int AW = $clog2(RAMSIZE);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] DBG_A = AW'(DEBUG_ADDR);

  logic [1:0]            state;
  logic [AW-1:0]         lptr;
  logic [AW-1:0]         ip;
  logic [7:0]            ram  [RAMSIZE];
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // operands captured in FETCH, consumed in EXEC
  logic [7:0]            op_p0;
  logic [RW-1:0]         ridx_p0;
  logic [15:0]           addr_p0;
  logic [7:0]            rval_p0;
  logic [DATA_WIDTH-1:0] ra_p0;
  logic [DATA_WIDTH-1:0] rb_p0;

  logic [AW-1:0] ip1, ip2, ip3, fetch_ra;
  logic [15:0]   fetch_addr;
  logic [RW-1:0] fetch_ridx;
  logic [AW-1:0] addr_a;

  assign ip1        = ip + AW'(1);
  assign ip2        = ip + AW'(2);
  assign ip3        = ip + AW'(3);
  assign fetch_addr = {ram[ip3], ram[ip2]};
  assign fetch_ra   = fetch_addr[AW-1:0];
  assign fetch_ridx = ram[ip1][RW-1:0];
  assign addr_a     = addr_p0[AW-1:0];

  logic [DATA_WIDTH-1:0] alu_sum, alu_diff;
  logic                  alu_zero;

  reader_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (ra_p0),
    .b      (rb_p0),
    .sum    (alu_sum),
    .diff   (alu_diff),
    .a_zero (alu_zero)
  );

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  ram_we;
  logic [AW-1:0]         ram_wa;
  logic [7:0]            ram_wd;
  logic [AW-1:0]         next_ip;
  logic                  stop;
  logic                  bad;
  logic [7:0]            dbg_next;
  logic [DATA_WIDTH-1:0] r0_next, r1_next;

  assign load_ready = (state == LOAD);
  assign halted     = (state == HALT);
  assign ipointer   = 8'(ip);
  assign opCode     = op_p0;

  // Decode the latched instruction and steer the RAM write port
  always_comb begin
    wr_en   = 1'b0;
    wr_val  = '0;
    ram_we  = 1'b0;
    ram_wa  = lptr;
    ram_wd  = load_data;
    next_ip = ip + AW'(INSTR_BYTES);
    stop    = 1'b0;
    bad     = 1'b0;
    if (state == LOAD) begin
      ram_we = load_valid & reset;
    end else if (state == EXEC) begin
      case (op_p0)
        OP_NOP:   ;
        OP_MOVI:  begin wr_en = 1'b1; wr_val = DATA_WIDTH'(addr_p0); end
        OP_LOAD:  begin wr_en = 1'b1; wr_val = DATA_WIDTH'(rval_p0); end
        OP_STORE: begin ram_we = 1'b1; ram_wa = addr_a; ram_wd = ra_p0[7:0]; end
        OP_ADD:   begin wr_en = 1'b1; wr_val = alu_sum; end
        OP_SUB:   begin wr_en = 1'b1; wr_val = alu_diff; end
        OP_JMP:   next_ip = addr_a;
        OP_JZ:    if (alu_zero) next_ip = addr_a;
        OP_HALT:  stop = 1'b1;
        default:  begin stop = 1'b1; bad = 1'b1; end
      endcase
    end
    dbg_next = (ram_we && ram_wa == DBG_A) ? ram_wd : ram[DBG_A];
    r0_next  = (wr_en && ridx_p0 == RW'(0)) ? wr_val : regs[0];
    r1_next  = (wr_en && ridx_p0 == RW'(1)) ? wr_val : regs[1];
  end

  // Program/data RAM: single write port shared by loader and store
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  // Fetch-stage operand capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      ridx_p0 <= fetch_ridx;
      addr_p0 <= fetch_addr;
      rval_p0 <= ram[fetch_ra];
      ra_p0   <= regs[fetch_ridx];
      rb_p0   <= regs[fetch_addr[RW-1:0]];
    end
  end

  // Control FSM, register file and observation outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOAD;
      lptr    <= '0;
      ip      <= '0;
      op_p0   <= '0;
      r0      <= '0;
      r1      <= '0;
      debug   <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            lptr <= lptr + AW'(1);
            if (load_last || lptr == AW'(RAMSIZE - 1)) begin
              state <= FETCH;
              ip    <= '0;
            end
          end
        end
        FETCH: begin
          op_p0 <= ram[ip];
          state <= EXEC;
        end
        EXEC: begin
          if (wr_en) regs[ridx_p0] <= wr_val;
          r0    <= r0_next;
          r1    <= r1_next;
          debug <= DATA_WIDTH'(dbg_next);
          if (stop) begin
            state <= HALT;
            if (bad) illegal <= 1'b1;
          end else begin
            ip    <= next_ip;
            state <= FETCH;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef READER_TRACE_EN
  // Retirement trace: one pulse per executed instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
    end else begin
      trace_valid <= (state == EXEC);
      if (state == EXEC) trace_pc <= 8'(ip);
    end
  end
`endif

endmodule
